// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction stream loader.
package loader_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERROR} loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/instr_stream_loader.sv
// Streams a program into instruction memory, holds the core in reset while loading
// and counts run cycles. Optional checksum output under LOADER_CHECKSUM_EN.
module instr_stream_loader
    import loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               s_valid,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic [WIDTH-1:0]   instr_in,
    output logic [LOGSIZE+1:0] instr_wr_addr,
    output logic               instr_wr_en,
    output logic               core_reset,
    output logic               load_done,
    output logic [LOGSIZE:0]   word_count,
    output logic               overflow,
    output logic [31:0]        cycle_count,
    output logic [2:0]         state
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]   checksum
`endif
);

    localparam int ADDR_W = LOGSIZE + 2;
    localparam int CNT_W  = LOGSIZE + 1;

    // Handshake: a word transfers on every rising edge where s_valid && s_ready;
    // s_ready is high exactly in LOAD and the producer must hold data while s_valid && !s_ready.
    loader_state_t fsm;
    logic          xfer;
    logic          start_ok;

    assign s_ready  = (fsm == LOAD);
    assign xfer     = s_valid && s_ready;
    assign start_ok = start && ((fsm == IDLE) || (fsm == RUN) || (fsm == ERROR));
    assign state    = fsm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm           <= IDLE;
            core_reset    <= 1'b1;
            instr_wr_en   <= 1'b0;
            instr_in      <= '0;
            instr_wr_addr <= '0;
            word_count    <= '0;
            load_done     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            instr_wr_en <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_ok) begin
                        fsm        <= LOAD;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        instr_wr_en   <= 1'b1;
                        instr_in      <= s_data;
                        instr_wr_addr <= ADDR_W'(word_count[LOGSIZE-1:0]) * ADDR_W'(BYTES_PER_WORD);
                        word_count    <= word_count + CNT_W'(1);
                        if (s_last) begin
                            fsm <= DRAIN;
                        end else if (word_count == CNT_W'(SIZE - 1)) begin
                            // The SIZE-th word filled memory without ending the program.
                            fsm      <= ERROR;
                            overflow <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    fsm        <= RUN;
                    core_reset <= 1'b0;
                    load_done  <= 1'b1;
                end
                RUN: begin
                    if (start_ok) begin
                        fsm        <= LOAD;
                        core_reset <= 1'b1;
                        load_done  <= 1'b0;
                        word_count <= '0;
                    end
                end
                ERROR: begin
                    if (start_ok) begin
                        fsm        <= LOAD;
                        overflow   <= 1'b0;
                        word_count <= '0;
                    end
                end
                default: begin
                    fsm        <= IDLE;
                    core_reset <= 1'b1;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(32)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .en    (fsm == RUN),
        .clr   (start_ok),
        .count (cycle_count)
    );

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized bench for instr_stream_loader: write scoreboard plus load/run/overflow/reset scenarios.
module tb_instr_stream_loader;
    import loader_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 64;
    localparam int LOGSIZE = $clog2(SIZE);
    localparam int AW      = LOGSIZE + 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_last = 1'b0;
    logic [WIDTH-1:0]   s_data = '0;
    logic               s_ready;
    logic [WIDTH-1:0]   instr_in;
    logic [AW-1:0]      instr_wr_addr;
    logic               instr_wr_en;
    logic               core_reset;
    logic               load_done;
    logic [LOGSIZE:0]   word_count;
    logic               overflow;
    logic [31:0]        cycle_count;
    logic [2:0]         state;
`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]   checksum;
`endif

    instr_stream_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .instr_in      (instr_in),
        .instr_wr_addr (instr_wr_addr),
        .instr_wr_en   (instr_wr_en),
        .core_reset    (core_reset),
        .load_done     (load_done),
        .word_count    (word_count),
        .overflow      (overflow),
        .cycle_count   (cycle_count),
        .state         (state)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int m_words = 0;
    logic [WIDTH-1:0] m_sum = '0;
    logic [71:0] exp_q[$];
    logic [WIDTH-1:0] prog[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each write is {expected negedge index, byte address, data}.
    always @(negedge clk) begin
        logic [71:0] e;
        ncyc++;
        if (instr_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(instr_wr_en), 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", 64'(ncyc), 64'(e[71:40]));
                check("wr_addr", 64'(instr_wr_addr), 64'(e[39:32]));
                check("wr_data", 64'(instr_in), 64'(e[31:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_core_reset", 64'(core_reset), 64'h1);
        check("rst_s_ready", 64'(s_ready), 64'h0);
        check("rst_wr_en", 64'(instr_wr_en), 64'h0);
        check("rst_instr_in", 64'(instr_in), 64'h0);
        check("rst_wr_addr", 64'(instr_wr_addr), 64'h0);
        check("rst_word_count", 64'(word_count), 64'h0);
        check("rst_load_done", 64'(load_done), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_cycle_count", 64'(cycle_count), 64'h0);
        check("rst_state", 64'(state), 64'(IDLE));
    endtask

    task automatic start_load();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        s_valid = 1'b0;
        m_words = 0;
        m_sum = '0;
        check("ld_core_reset", 64'(core_reset), 64'h1);
        check("ld_word_count", 64'(word_count), 64'h0);
        check("ld_overflow", 64'(overflow), 64'h0);
        check("ld_load_done", 64'(load_done), 64'h0);
        check("ld_cycle_count", 64'(cycle_count), 64'h0);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        check("s_ready", 64'(s_ready), 64'h1);
        exp_q.push_back({32'(ncyc + 2), AW'(m_words * BYTES_PER_WORD), d});
        m_words++;
        m_sum += d;
        tick(1);
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = $urandom;
    endtask

    task automatic run_load(input int gap_min, input int gap_max, input bit with_last);
        int n = prog.size();
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(gap_max, gap_min);
            if (g > 0) tick(g);
            send_word(prog[i], with_last && (i == n - 1));
        end
        if (with_last) begin
            check("drain_s_ready", 64'(s_ready), 64'h0);
            check("drain_core_reset", 64'(core_reset), 64'h1);
            tick(1);
            check("run_core_reset", 64'(core_reset), 64'h0);
            check("run_load_done", 64'(load_done), 64'h1);
            check("run_word_count", 64'(word_count), 64'(n));
            check("run_overflow", 64'(overflow), 64'h0);
            check("run_cycles0", 64'(cycle_count), 64'h0);
`ifdef LOADER_CHECKSUM_EN
            check("run_checksum", 64'(checksum), 64'(m_sum));
`endif
        end else begin
            check("err_overflow", 64'(overflow), 64'h1);
            check("err_s_ready", 64'(s_ready), 64'h0);
            check("err_core_reset", 64'(core_reset), 64'h1);
            check("err_load_done", 64'(load_done), 64'h0);
            check("err_word_count", 64'(word_count), 64'(SIZE));
            check("err_state", 64'(state), 64'(ERROR));
            tick(3);
            check("err_hold_overflow", 64'(overflow), 64'h1);
            check("err_hold_core_reset", 64'(core_reset), 64'h1);
            check("err_hold_s_ready", 64'(s_ready), 64'h0);
        end
    endtask

    task automatic fill_random(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    initial begin
        int k;
        reset = 1'b0;
        tick(3);
        check_reset_vals();
        reset = 1'b1;
        tick(2);

        // Start with a simultaneous valid word in IDLE: the word must not be taken.
        s_valid = 1'b1;
        s_data = 32'hDEAD_BEEF;
        check("idle_s_ready", 64'(s_ready), 64'h0);
        start_load();

        prog.delete();
        prog.push_back(32'h0050_0093);
        prog.push_back(32'h00A0_0113);
        prog.push_back(32'h0020_81B3);
        run_load(0, 0, 1);

        tick(100);
        check("cycles_100", 64'(cycle_count), 64'd100);
        start_load();
        fill_random(2);
        run_load(0, 0, 1);
        tick(7);
        check("cycles_7", 64'(cycle_count), 64'd7);

        // Alternating valid: gap of exactly one idle cycle before each word.
        start_load();
        fill_random(4);
        run_load(1, 1, 1);

        for (int r = 0; r < 6; r++) begin
            start_load();
            fill_random((r == 0) ? 1 : $urandom_range(SIZE, 2));
            run_load(0, 2, 1);
            k = $urandom_range(9, 1);
            tick(k);
            check("rand_cycles", 64'(cycle_count), 64'(k));
        end

        start_load();
        fill_random(SIZE);
        run_load(0, 0, 1);

        start_load();
        fill_random(SIZE);
        run_load(0, 1, 0);

        start_load();
        prog.delete();
        prog.push_back(32'hFFFF_FFFF);
        prog.push_back(32'h0000_0002);
        run_load(0, 0, 1);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_wrap", 64'(checksum), 64'h1);
`endif

        // Reset in the middle of a 10-word load.
        start_load();
        fill_random(10);
        for (int i = 0; i < 5; i++) send_word(prog[i], 1'b0);
        tick(1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals();
        check("rst_pending_writes", 64'(exp_q.size()), 64'h0);
        tick(2);
        reset = 1'b1;
        tick(1);
        start_load();
        fill_random(3);
        run_load(0, 1, 1);

        tick(2);
        check("wr_all_seen", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Hardware program loader in front of the single-cycle/pipelined core's instruction memory.
- Accepts instruction words on a valid/ready stream and writes them to consecutive word-aligned byte addresses.
- Holds the core in reset while loading, releases it when the load completes, and counts run cycles.
- Replaces bench-driven instruction writes; supports reload without a global reset and detects program overflow.

Parameters:
- WIDTH, 32, instruction/data word width.
- SIZE, 64, instruction memory depth in words; must be a power of two and at least 2.
- LOGSIZE, $clog2(SIZE), localparam; word index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from IDLE, RUN or ERROR.
- s_valid  in  1  stream word valid.
- s_data  in  WIDTH  stream instruction word.
- s_last  in  1  marks the final word of the program.
- s_ready  out  1  loader accepts a word this cycle.
- instr_in  out  WIDTH  write data to instruction memory.
- instr_wr_addr  out  LOGSIZE+2  byte write address; bits [1:0] are always 0.
- instr_wr_en  out  1  instruction memory write enable.
- core_reset  out  1  active-high reset to the core.
- load_done  out  1  high while in RUN.
- word_count  out  LOGSIZE+1  number of words accepted in the current or last load.
- overflow  out  1  sticky; a program longer than SIZE words was offered.
- cycle_count  out  32  core cycles since release; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, core_reset=1, s_ready=0, instr_wr_en=0;
  - instr_in=0, instr_wr_addr=0, word_count=0;
  - load_done=0, overflow=0, cycle_count=0.
- States: IDLE, LOAD, DRAIN, RUN, ERROR. All outputs are registered except s_ready, which is decoded from state.
- IDLE:
  - core_reset=1, s_ready=0.
  - start -> LOAD; clear word_count, overflow and cycle_count.
- LOAD:
  - s_ready=1 and core_reset=1.
  - Transfer occurs when s_valid&&s_ready. On the next cycle: instr_wr_en=1, instr_in=s_data, instr_wr_addr=word_count*4 (the pre-increment count). word_count increments by 1.
  - Write latency is exactly 1 cycle, so back-to-back transfers produce back-to-back writes.
  - No transfer in a cycle -> instr_wr_en=0 on the next cycle.
  - Transfer with s_last=1 -> DRAIN.
  - Transfer with s_last=0 and word_count==SIZE-1 before the increment (SIZE-th word) -> ERROR; overflow=1. That word is still written, to address (SIZE-1)*4.
  - start is ignored in LOAD.
- DRAIN:
  - One cycle. s_ready=0; the final write lands (instr_wr_en=1).
  - -> RUN.
- RUN:
  - core_reset=0, load_done=1, instr_wr_en=0.
  - cycle_count increments every cycle and saturates at its maximum.
  - start -> LOAD; core_reset=1 and load_done=0 from the next cycle; word_count and cycle_count cleared.
- ERROR:
  - core_reset=1, s_ready=0, load_done=0; overflow held.
  - start -> LOAD and clears overflow.
- Exactly SIZE words with s_last on the last word is legal: DRAIN then RUN, overflow=0.
- A one-word program is legal: word_count=1, core released after the DRAIN cycle.
- Reset asserted mid-LOAD aborts the load immediately; memory contents are undefined, the core is held in reset.
- start and a transfer in the same IDLE cycle: the transfer is not taken (s_ready=0 in IDLE).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[WIDTH-1:0], reset to 0 and cleared on start.
  - On each transfer, checksum <= checksum + s_data (modulo 2^WIDTH), updated one cycle after the transfer.
  - Lets the bench confirm the stream arrived intact.
- Undefined: no checksum port and no adder; all other behaviour is identical.

Decomposition:
- Shared package loader_pkg:
  - typedef enum logic [2:0] loader_state_t {IDLE, LOAD, DRAIN, RUN, ERROR};
  - localparam BYTES_PER_WORD=4.
- Sub-module: sat_counter (parametrised width, enable, clear, saturating), used for cycle_count. The word counter stays inline.

Test Plan:
- Reset, then start; stream 3 words 0x00500093, 0x00A00113, 0x002081B3 (last on the third), s_valid held high -> writes at addresses 0, 4, 8 on consecutive cycles; word_count=3; core_reset falls 2 cycles after the third transfer; load_done=1.
- s_valid toggling 1,0,1,0 over 4 words -> instr_wr_en pattern 1,0,1,0, each one cycle after its transfer; addresses 0, 4, 8, 12 with no gaps in addressing.
- SIZE=64, 64 words with s_last on the 64th -> last write at address 252, RUN, overflow=0. Repeat with s_last withheld -> ERROR, overflow=1, core_reset stays 1, s_ready=0.
- In RUN after 100 cycles (cycle_count=100), pulse start and load 2 words -> core_reset=1 the next cycle; word_count restarts from 0 to 2; cycle_count restarts from 0 after release.
- Assert reset after 5 of 10 words -> all outputs return to their reset values asynchronously; a subsequent start reloads from address 0.
- With LOADER_CHECKSUM_EN defined, stream 0xFFFFFFFF, 0x00000002 -> checksum=0x00000001 (wrap-around).
